// File: rtl/bcd_updown_scan.sv
// bcd_updown_scan
//
// N-digit BCD up/down counter driving a time-multiplexed common-anode style
// 7-segment display. A free-running tick divider sets the count rate. The
// counter supports enable, direction, synchronous preset and a one-cycle wrap
// flag. A refresh divider walks a one-hot digit enable across the displays,
// with optional leading-zero blanking. All outputs are registered.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst_n        asynchronous reset, active-HIGH (1 = reset asserted)
//   en_i         count enable, sampled only on tick edges
//   up_i         direction, 1 = increment, 0 = decrement, sampled on tick edges
//   load_i       synchronous preset strobe, overrides a coincident tick
//   load_val_i   preset value, digit i in bits [4i+3:4i]; digits > 9 load as 0
//   blank_lz_i   1 = blank leading zero digits (digit 0 is never blanked)
//   count_o      current BCD value, digit 0 least significant
//   wrap_o       one-cycle pulse after a roll-over / roll-under
//   seg_o        segments {g,f,e,d,c,b,a}, active-low
//   an_o         digit enables, one-hot, active-high

module bcd_updown_scan #(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned TICK_HZ     = 4,
    parameter int unsigned NUM_DIGITS  = 2,
    parameter int unsigned REFRESH_DIV = 131072
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    up_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_val_i,
    input  logic                    blank_lz_i,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic                    wrap_o,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int unsigned TickDiv = CLK_FREQ / TICK_HZ;
    localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int unsigned ScanW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CntW    = 4 * NUM_DIGITS;

    localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);
    localparam logic [ScanW-1:0] ScanLast = ScanW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_DIGITS - 1);

    localparam logic [6:0] SegOff = 7'b1111111;

    // Active-low segment pattern for one BCD digit; non-decimal codes go dark.
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SegOff;
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        if (tick_cnt_q == TickLast) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
        end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
            tick_d     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // BCD counter
    // ------------------------------------------------------------------
    logic [CntW-1:0] count_q, count_d;
    logic            wrap_q, wrap_d;
    logic [CntW-1:0] load_clean;
    logic [CntW-1:0] step_val;
    logic            step_wrap;
    logic            carry;
    logic [3:0]      digit;
    logic [3:0]      nib;

    // Preset with each out-of-range digit forced to zero.
    always_comb begin
        load_clean = '0;
        nib        = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib                  = load_val_i[4*i +: 4];
            load_clean[4*i +: 4] = (nib > 4'd9) ? 4'd0 : nib;
        end
    end

    // Ripple one step through the digits; carry doubles as borrow when counting
    // down. A carry surviving the top digit means the whole value wrapped.
    always_comb begin
        step_val = count_q;
        carry    = 1'b1;
        digit    = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                if (up_i) begin
                    if (digit == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = digit + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = digit - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        step_wrap = carry;
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load_i) begin
            count_d = load_clean;
        end else if (tick_q && en_i) begin
            count_d = step_val;
            wrap_d  = step_wrap;
        end
    end

    // ------------------------------------------------------------------
    // Display scanner
    // ------------------------------------------------------------------
    logic [ScanW-1:0]    scan_cnt_q, scan_cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [NUM_DIGITS:0] upper_zero;
    logic [3:0]          sel_digit;
    logic                sel_blank;

    always_comb begin
        if (scan_cnt_q == ScanLast) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end else begin
            scan_cnt_d = scan_cnt_q + ScanW'(1);
            idx_d      = idx_q;
        end
    end

    // upper_zero[i]: digit i and every digit above it are zero.
    always_comb begin
        upper_zero             = '0;
        upper_zero[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] & (count_q[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        sel_digit = 4'd0;
        sel_blank = 1'b0;
        an_d      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                sel_digit = count_q[4*i +: 4];
                sel_blank = blank_lz_i && (i != 0) && upper_zero[i];
                an_d[i]   = 1'b1;
            end
        end
        seg_d = sel_blank ? SegOff : seg_pattern(sel_digit);
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= SegOff;
            an_q       <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;
    assign seg_o   = seg_q;
    assign an_o    = an_q;

endmodule

// File: tb/tb_bcd_updown_scan.sv
// Testbench for bcd_updown_scan: CLK_FREQ=100, TICK_HZ=10, NUM_DIGITS=3,
// REFRESH_DIV=4. An integer-valued reference model tracks the expected
// count, wrap, segment and anode outputs edge by edge.

module tb_bcd_updown_scan;

    localparam int unsigned ND = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          up = 1'b1;
    logic          load = 1'b0;
    logic [11:0]   load_val = 12'h000;
    logic          blank_lz = 1'b0;
    logic [11:0]   count_o;
    logic          wrap_o;
    logic [6:0]    seg_o;
    logic [ND-1:0] an_o;

    always #5 clk = ~clk;

    bcd_updown_scan #(
        .CLK_FREQ   (100),
        .TICK_HZ    (10),
        .NUM_DIGITS (ND),
        .REFRESH_DIV(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en),
        .up_i      (up),
        .load_i    (load),
        .load_val_i(load_val),
        .blank_lz_i(blank_lz),
        .count_o   (count_o),
        .wrap_o    (wrap_o),
        .seg_o     (seg_o),
        .an_o      (an_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since reset release, value as a plain integer.
    int         n = 0;
    int         mval = 0;
    logic       mwrap = 1'b0;
    logic [6:0] mseg = 7'h7F;
    logic [2:0] man = 3'b000;

    logic [6:0] pat [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    function automatic int sanitize(input logic [11:0] v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < 3; i++) begin
            int d;
            d = int'((v >> (4 * i)) & 12'hF);
            if (d > 9) d = 0;
            r += d * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] disp(input int v, input int idx, input logic blank);
        int p;
        p = (idx == 0) ? 1 : ((idx == 1) ? 10 : 100);
        if (blank && idx > 0 && v < p) return 7'h7F;
        return pat[(v / p) % 10];
    endfunction

    task automatic model_step();
        int  idx;
        bit  tick_pre;
        n++;
        tick_pre = (n - 1 >= 10) && ((n - 1) % 10 == 0);
        idx      = ((n - 1) / 4) % 3;
        man      = 3'(1 << idx);
        mseg     = disp(mval, idx, blank_lz);
        mwrap    = 1'b0;
        if (load) begin
            mval = sanitize(load_val);
        end else if (tick_pre && en) begin
            if (up) begin
                mwrap = (mval == 999);
                mval  = (mval + 1) % 1000;
            end else begin
                mwrap = (mval == 0);
                mval  = (mval + 999) % 1000;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("count", 32'(count_o), 32'(to_bcd(mval)));
        chk("wrap", 32'(wrap_o), 32'(mwrap));
        chk("seg", 32'(seg_o), 32'(mseg));
        chk("an", 32'(an_o), 32'(man));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_count", 32'(count_o), 32'h000);
        chk("rst_seg", 32'(seg_o), 32'h7F);
        chk("rst_an", 32'(an_o), 32'h0);
        chk("rst_wrap", 32'(wrap_o), 32'h0);
        n     = 0;
        mval  = 0;
        mwrap = 1'b0;
        mseg  = 7'h7F;
        man   = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic wait_change(output bit ok);
        logic [11:0] prev;
        prev = count_o;
        ok   = 1'b0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (count_o != prev) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("count_change_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_load(input logic [11:0] v);
        load_val = v;
        load     = 1'b1;
        cyc();
        load     = 1'b0;
    endtask

    typedef struct {
        logic [11:0] lv;
        logic [11:0] exp;
    } load_vec_t;

    load_vec_t tbl [6];

    initial begin
        bit ok;

        tbl[0] = '{lv: 12'h999, exp: 12'h999};
        tbl[1] = '{lv: 12'h1A9, exp: 12'h109};
        tbl[2] = '{lv: 12'hFFF, exp: 12'h000};
        tbl[3] = '{lv: 12'h5B3, exp: 12'h503};
        tbl[4] = '{lv: 12'h0C0, exp: 12'h000};
        tbl[5] = '{lv: 12'h456, exp: 12'h456};

        // Count-up from reset and first-tick latency
        en = 1'b1; up = 1'b1;
        do_reset();
        cyc();
        chk("an_edge1", 32'(an_o), 32'b001);
        chk("seg_edge1", 32'(seg_o), 32'b1000000);
        while (n < 10) cyc();
        chk("count_edge10", 32'(count_o), 32'h000);
        cyc();
        chk("count_edge11", 32'(count_o), 32'h001);
        while (n < 101) cyc();
        chk("count_edge101", 32'(count_o), 32'h010);

        // Roll-over and roll-under
        do_load(12'h999);
        chk("load_999", 32'(count_o), 32'h999);
        wait_change(ok);
        chk("rollover_count", 32'(count_o), 32'h000);
        chk("rollover_wrap", 32'(wrap_o), 32'h1);
        up = 1'b0;
        cyc();
        chk("rollover_wrap_clear", 32'(wrap_o), 32'h0);
        wait_change(ok);
        chk("rollunder_count", 32'(count_o), 32'h999);
        chk("rollunder_wrap", 32'(wrap_o), 32'h1);
        cyc();
        chk("rollunder_wrap_clear", 32'(wrap_o), 32'h0);

        // Load table; even entries land exactly on a tick edge
        up = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                while (!(n >= 10 && n % 10 == 0)) cyc();
            end
            do_load(tbl[i].lv);
            chk("load_table", 32'(count_o), 32'(tbl[i].exp));
            chk("load_wrap", 32'(wrap_o), 32'h0);
            repeat (3) cyc();
        end

        // Enable low holds across ticks; up only matters at the tick edge
        do_load(12'h123);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            up = ~up;
            cyc();
        end
        chk("en_hold", 32'(count_o), 32'h123);
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            up = ~up;
            cyc();
        end

        // Leading-zero blanking with count = 007
        en = 1'b0;
        do_load(12'h007);
        blank_lz = 1'b1;
        repeat (2) cyc();
        for (int i = 0; i < 12; i++) begin
            cyc();
            case (an_o)
                3'b001:  chk("blank_d0", 32'(seg_o), 32'b1111000);
                3'b010:  chk("blank_d1", 32'(seg_o), 32'b1111111);
                3'b100:  chk("blank_d2", 32'(seg_o), 32'b1111111);
                default: chk("an_onehot", 32'(an_o), 32'b001);
            endcase
        end
        blank_lz = 1'b0;
        cyc();
        for (int i = 0; i < 12; i++) begin
            cyc();
            case (an_o)
                3'b001:  chk("noblank_d0", 32'(seg_o), 32'b1111000);
                3'b010:  chk("noblank_d1", 32'(seg_o), 32'b1000000);
                3'b100:  chk("noblank_d2", 32'(seg_o), 32'b1000000);
                default: chk("an_onehot", 32'(an_o), 32'b001);
            endcase
        end

        // Reset mid-scan with count = 456
        do_load(12'h456);
        repeat (6) cyc();
        do_reset();
        en = 1'b1; up = 1'b1;
        repeat (30) cyc();

        // Randomized operation against the model
        for (int i = 0; i < 2000; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            up       = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 29) == 0);
            blank_lz = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       load_val = 12'h999;
                1:       load_val = 12'h000;
                default: load_val = 12'($urandom);
            endcase
            if ($urandom_range(0, 499) == 0) do_reset();
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
